zmips_alu_md: RTL and testbench

Parametrised, registered successor to the zmips combinational ALU. It adds iterative multiply/divide with HI/LO result registers and a start/ready/valid handshake. The data width is a parameter. The block sits in the EX stage. Single-cycle ops return in one clock; multiply/divide ops stall EX until the handshake reports `valid`.

---
 rtl/zmips_alu_md_if.sv | 30 +++
 rtl/zmips_alu_md.sv | 269 ++++++++++++++++++++++++++
 tb/tb_zmips_alu_md.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zmips_alu_md_if.sv
// Request/response bundle for the zmips EX-stage ALU with multiply/divide.
// The master (pipeline) issues requests; the slave (ALU) returns results.
interface zmips_alu_md_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [4:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               cin;
  logic               ready;
  logic               valid;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               zero;
  logic               cout;

  modport master (
    output start, op, a, b, shamt, cin,
    input  ready, valid, y, hi, lo, zero, cout
  );

  modport slave (
    input  start, op, a, b, shamt, cin,
    output ready, valid, y, hi, lo, zero, cout
  );
endinterface

// File: rtl/zmips_alu_md.sv
// Registered zmips ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide into HI/LO, with start/ready/valid.
module zmips_alu_md #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  zmips_alu_md_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic               ready_c;
  logic               accept;
  logic               multi_op;

  logic [WIDTH-1:0]   y_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               zero_reg;
  logic               cout_reg;
  logic               valid_reg;

  // Iteration state shared by multiply and divide
  logic [SHAMT_W-1:0] cnt_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]   mq_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic               is_div_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               dz_reg;

  assign multi_op = bus.op[4];
  assign accept   = ready_c & bus.start;

  // ------------------------------------------------------------------
  // Single-cycle datapath
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] b_in;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sll_ext;
  logic [WIDTH:0]   srl_ext;
  logic [WIDTH:0]   sra_ext;
  logic [WIDTH-1:0] sc_y;
  logic             sc_cout;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_in
      assign b_in[gi] = bus.b[gi] ^ bus.op[0];
    end
  endgenerate

  assign add_sum = {1'b0, bus.a} + {1'b0, b_in} + {{WIDTH{1'b0}}, bus.cin};

  // One extra bit on the shifted-out side captures the last bit lost,
  // and is naturally zero when shamt is zero.
  assign sll_ext = {1'b0, bus.a} << bus.shamt;
  assign srl_ext = {bus.a, 1'b0} >> bus.shamt;
  assign sra_ext = $signed({bus.a, 1'b0}) >>> bus.shamt;

  always_comb begin
    sc_y    = '0;
    sc_cout = 1'b0;
    if (!bus.op[3]) begin
      case (bus.op[2:1])
        2'd0: begin
          sc_y    = add_sum[WIDTH-1:0];
          sc_cout = add_sum[WIDTH];
        end
        2'd1:    sc_y = bus.a & b_in;
        2'd2:    sc_y = bus.a | b_in;
        default: sc_y = bus.a ^ b_in;
      endcase
    end else begin
      case (bus.op[2:1])
        2'd0: sc_y = bus.a;
        2'd1: begin
          sc_y    = sll_ext[WIDTH-1:0];
          sc_cout = sll_ext[WIDTH];
        end
        2'd2: begin
          sc_y    = sra_ext[WIDTH:1];
          sc_cout = sra_ext[0];
        end
        default: begin
          sc_y    = srl_ext[WIDTH:1];
          sc_cout = srl_ext[0];
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Multi-cycle operand preparation (magnitudes and latched signs)
  // ------------------------------------------------------------------
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign signed_op = bus.op[0];
  assign a_neg     = signed_op & bus.a[WIDTH-1];
  assign b_neg     = signed_op & bus.b[WIDTH-1];
  assign a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;

  // ------------------------------------------------------------------
  // Per-iteration step
  // ------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mq_step;

  assign mul_sum  = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  assign rem_sh   = {acc_reg, mq_reg[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, mcand_reg};
  // The partial remainder stays below the divisor, so the difference fits WIDTH bits
  assign rem_diff = rem_sh[WIDTH-1:0] - mcand_reg;

  always_comb begin
    acc_step = acc_reg;
    mq_step  = mq_reg;
    if (is_div_reg) begin
      acc_step = div_ge ? rem_diff : rem_sh[WIDTH-1:0];
      mq_step  = {mq_reg[WIDTH-2:0], div_ge};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      mq_step  = {mul_sum[0], mq_reg[WIDTH-1:1]};
    end
  end

  // ------------------------------------------------------------------
  // Sign correction and divide-by-zero handling in FIX
  // ------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  assign prod_raw = {acc_reg, mq_reg};
  assign prod_fix = neg_q_reg ? (~prod_raw + 1'b1) : prod_raw;
  assign q_fix    = neg_q_reg ? (~mq_reg + 1'b1) : mq_reg;
  // With a zero divisor the remainder path returns |a|, so this yields hi = a
  assign r_fix    = neg_r_reg ? (~acc_reg + 1'b1) : acc_reg;

  always_comb begin
    hi_fix = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      hi_fix = r_fix;
      lo_fix = dz_reg ? {WIDTH{1'b1}} : q_fix;
    end
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept && multi_op) state_next = S_RUN;
      S_RUN:   if (cnt_reg == '0) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready_c = 1'b0;
    case (state_reg)
      S_IDLE:  ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath and result registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      zero_reg   <= 1'b1;
      cout_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mq_reg     <= '0;
      mcand_reg  <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            if (!multi_op) begin
              y_reg     <= sc_y;
              cout_reg  <= sc_cout;
              zero_reg  <= ~|sc_y;
              valid_reg <= 1'b1;
            end else begin
              cnt_reg    <= SHAMT_W'(WIDTH - 1);
              acc_reg    <= '0;
              mq_reg     <= a_mag;
              mcand_reg  <= b_mag;
              is_div_reg <= bus.op[1];
              neg_q_reg  <= a_neg ^ b_neg;
              neg_r_reg  <= a_neg;
              dz_reg     <= bus.op[1] & (bus.b == '0);
            end
          end
        end
        S_RUN: begin
          acc_reg <= acc_step;
          mq_reg  <= mq_step;
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_FIX: begin
          hi_reg    <= hi_fix;
          lo_reg    <= lo_fix;
          y_reg     <= lo_fix;
          zero_reg  <= ~|lo_fix;
          cout_reg  <= is_div_reg & dz_reg;
          valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = ready_c;
  assign bus.valid = valid_reg;
  assign bus.y     = y_reg;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.zero  = zero_reg;
  assign bus.cout  = cout_reg;

endmodule

// File: tb/tb_zmips_alu_md.sv
// Self-checking bench for zmips_alu_md: directed cases, randomized ops against
// an arithmetic reference model, handshake, mid-op reset and a 16-bit instance.
module tb_zmips_alu_md;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  zmips_alu_md_if #(.WIDTH(32), .SHAMT_W(5)) bus32 ();
  zmips_alu_md_if #(.WIDTH(16), .SHAMT_W(4)) bus16 ();

  zmips_alu_md #(.WIDTH(32), .SHAMT_W(5)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  zmips_alu_md #(.WIDTH(16), .SHAMT_W(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: hi/lo persist between multi-cycle ops
  logic [31:0] exp_y;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic        exp_cout;
  logic        exp_multi;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic cin);
    logic [31:0]     bi;
    logic [63:0]     s64;
    longint unsigned pu;
    longint          ps;
    longint          la;
    longint          lb;
    longint          lq;
    longint          lr;
    int              ia;
    int              ib;
    int              s;
    s         = int'(sh);
    exp_multi = op[4];
    exp_cout  = 1'b0;
    if (op[4]) begin
      case (op[1:0])
        2'd0: begin
          pu = {32'b0, a} * {32'b0, b};
          exp_hi = pu[63:32];
          exp_lo = pu[31:0];
        end
        2'd1: begin
          ia = a; ib = b; la = ia; lb = ib;
          ps = la * lb;
          exp_hi = ps[63:32];
          exp_lo = ps[31:0];
        end
        default: begin
          if (b == 32'd0) begin
            exp_lo   = 32'hFFFF_FFFF;
            exp_hi   = a;
            exp_cout = 1'b1;
          end else if (op[0] == 1'b0) begin
            exp_lo = a / b;
            exp_hi = a % b;
          end else begin
            ia = a; ib = b; la = ia; lb = ib;
            lq = la / lb;
            lr = la % lb;
            exp_lo = lq[31:0];
            exp_hi = lr[31:0];
          end
        end
      endcase
      exp_y = exp_lo;
    end else if (!op[3]) begin
      bi = op[0] ? ~b : b;
      case (op[2:1])
        2'd0: begin
          s64 = {32'b0, a} + {32'b0, bi} + {63'b0, cin};
          exp_y    = s64[31:0];
          exp_cout = s64[32];
        end
        2'd1:    exp_y = a & bi;
        2'd2:    exp_y = a | bi;
        default: exp_y = a ^ bi;
      endcase
    end else begin
      case (op[2:1])
        2'd0: exp_y = a;
        2'd1: begin
          exp_y    = a << s;
          exp_cout = (s == 0) ? 1'b0 : a[32-s];
        end
        2'd2: begin
          exp_y    = $signed(a) >>> s;
          exp_cout = (s == 0) ? 1'b0 : a[s-1];
        end
        default: begin
          exp_y    = a >> s;
          exp_cout = (s == 0) ? 1'b0 : a[s-1];
        end
      endcase
    end
  endtask

  // Issue one op on the 32-bit instance, wait for valid and compare everything
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic cin);
    int n;
    n = 0;
    while (bus32.ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    bus32.start = 1'b1;
    bus32.op    = op;
    bus32.a     = a;
    bus32.b     = b;
    bus32.shamt = sh;
    bus32.cin   = cin;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    bus32.a     = $urandom;
    bus32.b     = $urandom;
    model(op, a, b, sh, cin);
    n = 0;
    while (bus32.valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    // Edges counted after the accepting edge: WIDTH+1 for multi-cycle ops
    check({name, " latency"}, 64'(n), exp_multi ? 64'd33 : 64'd0);
    check({name, " y"},    64'(bus32.y),    64'(exp_y));
    check({name, " cout"}, 64'(bus32.cout), 64'(exp_cout));
    check({name, " zero"}, 64'(bus32.zero), 64'(exp_y == 32'd0));
    check({name, " hi"},   64'(bus32.hi),   64'(exp_hi));
    check({name, " lo"},   64'(bus32.lo),   64'(exp_lo));
    $display("op %s op=%02h a=%08h b=%08h sh=%0d cin=%0b -> y=%08h hi=%08h lo=%08h cout=%0b lat=%0d",
             name, op, a, b, sh, cin, bus32.y, bus32.hi, bus32.lo, bus32.cout, n);
    @(posedge clk); #1;
    check({name, " valid pulse"}, 64'(bus32.valid), 64'd0);
  endtask

  initial begin
    int          n;
    int          vcount;
    logic [4:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus32.start = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0; bus32.shamt = '0; bus32.cin = 1'b0;
    bus16.start = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0; bus16.shamt = '0; bus16.cin = 1'b0;
    exp_y = '0; exp_hi = '0; exp_lo = '0; exp_cout = 1'b0; exp_multi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst ready", 64'(bus32.ready), 64'd1);
    check("rst valid", 64'(bus32.valid), 64'd0);
    check("rst y",     64'(bus32.y),     64'd0);
    check("rst hi",    64'(bus32.hi),    64'd0);
    check("rst lo",    64'(bus32.lo),    64'd0);
    check("rst cout",  64'(bus32.cout),  64'd0);
    check("rst zero",  64'(bus32.zero),  64'd1);
    check("rst16 ready", 64'(bus16.ready), 64'd1);

    // Directed cases
    run_op("add_carry", 5'h00, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
    run_op("sub",       5'h01, 32'd5, 32'd7, 5'd0, 1'b1);
    run_op("andn",      5'h03, 32'hF0F0_1234, 32'h0FF0_0F00, 5'd0, 1'b0);
    run_op("xnor",      5'h07, 32'h1234_5678, 32'h1234_5678, 5'd0, 1'b0);
    run_op("sra",       5'h0C, 32'h8000_0001, 32'h0, 5'd1, 1'b0);
    run_op("sll0",      5'h0A, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0);
    run_op("srl",       5'h0E, 32'h0000_00F0, 32'h0, 5'd4, 1'b0);
    run_op("sll31",     5'h0A, 32'h0000_0003, 32'h0, 5'd31, 1'b0);
    run_op("mult",      5'h11, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0);
    run_op("multu",     5'h10, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0);
    run_op("div",       5'h13, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0);
    run_op("divu_z",    5'h12, 32'd9, 32'd0, 5'd0, 1'b0);
    run_op("div_ovf",   5'h13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
    run_op("div_z_neg", 5'h13, 32'hFFFF_FF00, 32'd0, 5'd0, 1'b0);
    run_op("pass_keep", 5'h08, 32'h0000_0000, 32'h5, 5'd3, 1'b1);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 5'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom), 1'($urandom));
    end

    // Handshake: start held high during RUN is ignored; ADD taken on the valid cycle
    bus32.start = 1'b1; bus32.op = 5'h10; bus32.a = 32'd3; bus32.b = 32'd5; bus32.cin = 1'b0;
    @(posedge clk); #1;
    bus32.op = 5'h00; bus32.a = 32'd1; bus32.b = 32'd2;
    n = 0;
    vcount = 0;
    while (bus32.valid !== 1'b1 && n < 100) begin
      if (bus32.ready !== 1'b0) vcount++;
      @(posedge clk); #1; n++;
    end
    check("hs ready low in run", 64'(vcount), 64'd0);
    check("hs latency", 64'(n), 64'd33);
    check("hs lo", 64'(bus32.lo), 64'd15);
    check("hs y",  64'(bus32.y),  64'd15);
    check("hs ready at valid", 64'(bus32.ready), 64'd1);
    @(posedge clk); #1;
    bus32.start = 1'b0;
    check("hs b2b valid", 64'(bus32.valid), 64'd1);
    check("hs b2b y",     64'(bus32.y),     64'd3);
    check("hs b2b lo",    64'(bus32.lo),    64'd15);
    $display("op handshake multu 3*5 then add 1+2 -> y=%08h lo=%08h", bus32.y, bus32.lo);

    // Reset during RUN aborts with no valid pulse
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.op = 5'h12; bus32.a = 32'd100; bus32.b = 32'd7;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst ready", 64'(bus32.ready), 64'd1);
    check("mrst valid", 64'(bus32.valid), 64'd0);
    check("mrst y",     64'(bus32.y),     64'd0);
    check("mrst hi",    64'(bus32.hi),    64'd0);
    check("mrst lo",    64'(bus32.lo),    64'd0);
    check("mrst cout",  64'(bus32.cout),  64'd0);
    check("mrst zero",  64'(bus32.zero),  64'd1);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus32.valid === 1'b1) vcount++;
    end
    check("mrst no valid", 64'(vcount), 64'd0);
    $display("op reset_mid_divu -> ready=%0b valid_pulses=%0d", bus32.ready, vcount);
    exp_hi = '0; exp_lo = '0;
    run_op("post_rst_mult", 5'h15, 32'hFFFF_FFF9, 32'h0000_0006, 5'd0, 1'b0);

    // 16-bit instance
    bus16.start = 1'b1; bus16.op = 5'h10; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    n = 0;
    while (bus16.valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("w16 latency", 64'(n), 64'd17);
    check("w16 hi", 64'(bus16.hi), 64'h FFFE);
    check("w16 lo", 64'(bus16.lo), 64'h0001);
    check("w16 y",  64'(bus16.y),  64'h0001);
    $display("op w16 multu FFFF*FFFF -> hi=%04h lo=%04h lat=%0d", bus16.hi, bus16.lo, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
